// File: rtl/fwd_hazard_tracker.sv
// Forwarding select and load-use stall generator for the decode stage.
// Latency: selects and stall are combinational; the scoreboard updates one edge after issue.
// Backpressure: stall holds IF/ID and PC and inserts a bubble; older tracker entries always advance.
//
// Ports:
//   clk, reset        - clock (rising edge) and asynchronous active-high reset
//   id_valid          - decode holds a real instruction
//   id_src            - packed source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used       - operand i is actually read
//   id_wr, id_dest    - decode instruction writes register id_dest
//   id_is_load        - decode instruction is a LOAD
//   flush             - kill the decode instruction
//   stall             - hold IF/ID and PC (combinational)
//   fwd_sel           - per-operand select, 0 = register file, k+1 = tracker stage k
//   stall_cnt         - saturating count of stall cycles
module fwd_hazard_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          id_wr,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt
);

  // One in-flight producer per stage past decode.
  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic [REG_ADDR_W-1:0] dest;
    logic                  ld;
  } entry_t;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  entry_t                  trk [FWD_DEPTH];
  entry_t                  entry_in;
  logic [REG_ADDR_W-1:0]   src [NUM_SRC];
  logic [SEL_W-1:0]        sel [NUM_SRC];
  logic [NUM_SRC-1:0]      found;
  logic [NUM_SRC-1:0]      not_ready;

  // Unpack the flat source-address bus.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src[i] = id_src[i*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  // Scan stages from youngest to oldest; the first hit per operand decides it,
  // so older producers of the same register are shadowed by newer ones.
  always_comb begin
    found     = '0;
    not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (!found[i] && id_valid && id_src_used[i] && (src[i] != ZERO_ADDR) &&
            trk[k].v && trk[k].wr && (trk[k].dest == src[i])) begin
          found[i] = 1'b1;
          // Load data only exists from stage LOAD_LAT onwards.
          if (!trk[k].ld || (k >= LOAD_LAT)) begin
            sel[i] = SEL_W'(k + 1);
          end else begin
            not_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // Flush overrides stall: the killed instruction cannot wait on anything.
  assign stall = id_valid && !flush && (|not_ready);

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = sel[i];
    end
  end

  // A stalled or flushed decode slot enters the tracker as a bubble.
  always_comb begin
    entry_in      = '0;
    entry_in.v    = id_valid && !flush && !stall;
    entry_in.wr   = id_wr;
    entry_in.dest = id_dest;
    entry_in.ld   = id_is_load;
  end

  // Shift register: every entry advances each edge, the oldest falls off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        trk[k] <= '0;
      end
    end else begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        trk[k] <= trk[k-1];
      end
      trk[0] <= entry_in;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
module tb_fwd_hazard_tracker;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_wr;
  logic [4:0]  id_dest;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  fwd_hazard_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_src     (id_src),
    .id_src_used(id_src_used),
    .id_wr      (id_wr),
    .id_dest    (id_dest),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one decode cycle: inputs and the expected combinational outputs.
  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic       wr;
    logic [4:0] dest;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic       chk_sel;
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic wr, input logic [4:0] dest,
                              input logic ld, input logic fl, input logic es, input logic ck,
                              input logic [1:0] e0, input logic [1:0] e1);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.wr = wr; r.dest = dest;
    r.ld = ld; r.fl = fl; r.e_stall = es; r.chk_sel = ck; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid    = r.v;
    id_src      = {r.s1, r.s0};
    id_src_used = r.used;
    id_wr       = r.wr;
    id_dest     = r.dest;
    id_is_load  = r.ld;
    flush       = r.fl;
  endtask

  initial begin
    //            v  s0 s1 used  wr dest ld fl  stall chk e0 e1
    vecs[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0);  // idle after reset
    vecs[1]  = mk(1, 1, 2, 2'b11, 1, 3, 0, 0,  0, 1, 0, 0);  // issue ALU -> r3
    vecs[2]  = mk(1, 3, 4, 2'b11, 0, 0, 0, 0,  0, 1, 1, 0);  // r3 at EX
    vecs[3]  = mk(1, 9, 3, 2'b11, 0, 0, 0, 0,  0, 1, 0, 2);  // r3 at MEM
    vecs[4]  = mk(1, 3, 3, 2'b11, 0, 0, 0, 0,  0, 1, 3, 3);  // r3 at WB, both operands
    vecs[5]  = mk(1, 3, 3, 2'b11, 1, 5, 1, 0,  0, 1, 0, 0);  // r3 retired; issue LOAD r5
    vecs[6]  = mk(1, 5, 0, 2'b01, 1, 5, 0, 0,  1, 0, 0, 0);  // load-use stall
    vecs[7]  = mk(1, 5, 0, 2'b01, 1, 5, 0, 0,  0, 1, 2, 0);  // released, load at MEM
    vecs[8]  = mk(1, 5, 0, 2'b01, 1, 7, 0, 0,  0, 1, 1, 0);  // r5 writer at EX shadows load
    vecs[9]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 2'b00, 1, 7, 0, 0,  0, 1, 0, 0);  // second r7 writer
    vecs[11] = mk(1, 7, 7, 2'b11, 1, 0, 0, 0,  0, 1, 1, 1);  // youngest r7 wins; writes r0
    vecs[12] = mk(1, 0, 0, 2'b11, 1, 6, 1, 0,  0, 1, 0, 0);  // r0 never matches; LOAD r6
    vecs[13] = mk(1, 6, 6, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0);  // unused operands: no stall
    vecs[14] = mk(1, 0, 0, 2'b00, 1, 8, 1, 0,  0, 1, 0, 0);  // LOAD r8
    vecs[15] = mk(1, 8, 0, 2'b01, 1, 8, 0, 1,  0, 0, 0, 0);  // flush beats load-use stall
    vecs[16] = mk(1, 8, 8, 2'b10, 0, 0, 0, 0,  0, 1, 0, 2);  // flushed slot was a bubble

    drive(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #3;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset fwd_sel", 32'(fwd_sel), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      if (vecs[i].chk_sel) begin
        chk($sformatf("row%0d sel0", i), 32'(fwd_sel[1:0]), 32'(vecs[i].e0));
        chk($sformatf("row%0d sel1", i), 32'(fwd_sel[3:2]), 32'(vecs[i].e1));
      end
    end

    // Exactly one stall cycle so far (row 6).
    @(negedge clk);
    drive(mk(1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0));  // LOAD r5
    #2;
    chk("stall_cnt after table", 32'(stall_cnt), 32'd1);

    // Reset while a load-use stall is active.
    @(negedge clk);
    drive(mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("mid stall before reset", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid stall async drop", 32'(stall), 32'd0);
    chk("mid stall cnt cleared", 32'(stall_cnt), 32'd0);
    chk("mid stall fwd_sel", 32'(fwd_sel), 32'd0);
    @(negedge clk);
    chk("reset held cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    #2;
    chk("post reset no stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("post reset cnt", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
